// File: rtl/pipe_stage_tracker.sv
// Shadow pipeline of per-instruction control tags (valid, PC, dest reg, write enable, branch)
// for the 5-stage MIPS core; define PERF_CNT_EN to build the performance counters.
module pipe_stage_tracker #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_rst,
    input  logic                  id_rst,
    input  logic                  exe_rst,
    input  logic                  mem_rst,
    input  logic                  wb_rst,
    input  logic                  if_en,
    input  logic                  id_en,
    input  logic                  exe_en,
    input  logic                  mem_en,
    input  logic                  wb_en,
    input  logic [PC_W-1:0]       if_pc,
    input  logic [REG_ADDR_W-1:0] id_regw_addr,
    input  logic                  id_wb_wen,
    input  logic                  id_is_branch,
    output logic                  if_valid,
    output logic                  id_valid,
    output logic                  exe_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic                  is_branch_exe,
    output logic                  is_branch_mem,
    output logic [REG_ADDR_W-1:0] regw_addr_exe,
    output logic [REG_ADDR_W-1:0] regw_addr_mem,
    output logic [REG_ADDR_W-1:0] regw_addr_wb,
    output logic                  wb_wen_exe,
    output logic                  wb_wen_mem,
    output logic                  wb_wen_wb,
    output logic [PC_W-1:0]       pc_id,
    output logic [PC_W-1:0]       pc_exe,
    output logic [PC_W-1:0]       pc_mem,
    output logic [PC_W-1:0]       pc_wb,
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      cyc_cnt,
    output logic [CNT_W-1:0]      retire_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic                  if_valid_d, if_valid_q;
    logic [PC_W-1:0]       if_pc_d, if_pc_q;
    logic                  id_valid_d, id_valid_q;
    logic [PC_W-1:0]       id_pc_d, id_pc_q;
    logic                  exe_valid_d, exe_valid_q;
    logic [PC_W-1:0]       exe_pc_d, exe_pc_q;
    logic [REG_ADDR_W-1:0] exe_regw_d, exe_regw_q;
    logic                  exe_wen_d, exe_wen_q;
    logic                  exe_br_d, exe_br_q;
    logic                  mem_valid_d, mem_valid_q;
    logic [PC_W-1:0]       mem_pc_d, mem_pc_q;
    logic [REG_ADDR_W-1:0] mem_regw_d, mem_regw_q;
    logic                  mem_wen_d, mem_wen_q;
    logic                  mem_br_d, mem_br_q;
    logic                  wb_valid_d, wb_valid_q;
    logic [PC_W-1:0]       wb_pc_d, wb_pc_q;
    logic [REG_ADDR_W-1:0] wb_regw_d, wb_regw_q;
    logic                  wb_wen_d, wb_wen_q;

    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if (if_rst) begin
            if_valid_d = 1'b0;
            if_pc_d    = '0;
        end else if (if_en) begin
            if_valid_d = 1'b1;
            if_pc_d    = if_pc;
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        if (id_rst) begin
            id_valid_d = 1'b0;
            id_pc_d    = '0;
        end else if (id_en) begin
            id_valid_d = if_valid_q;
            id_pc_d    = if_pc_q;
        end
    end

    // Tags are stored already masked by valid, so the feedback outputs come straight from flops.
    always_comb begin
        exe_valid_d = exe_valid_q;
        exe_pc_d    = exe_pc_q;
        exe_regw_d  = exe_regw_q;
        exe_wen_d   = exe_wen_q;
        exe_br_d    = exe_br_q;
        if (exe_rst) begin
            exe_valid_d = 1'b0;
            exe_pc_d    = '0;
            exe_regw_d  = '0;
            exe_wen_d   = 1'b0;
            exe_br_d    = 1'b0;
        end else if (exe_en) begin
            exe_valid_d = id_valid_q;
            exe_pc_d    = id_pc_q;
            exe_regw_d  = id_valid_q ? id_regw_addr : '0;
            exe_wen_d   = id_wb_wen & id_valid_q;
            exe_br_d    = id_is_branch & id_valid_q;
        end
    end

    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_pc_d    = mem_pc_q;
        mem_regw_d  = mem_regw_q;
        mem_wen_d   = mem_wen_q;
        mem_br_d    = mem_br_q;
        if (mem_rst) begin
            mem_valid_d = 1'b0;
            mem_pc_d    = '0;
            mem_regw_d  = '0;
            mem_wen_d   = 1'b0;
            mem_br_d    = 1'b0;
        end else if (mem_en) begin
            mem_valid_d = exe_valid_q;
            mem_pc_d    = exe_pc_q;
            mem_regw_d  = exe_regw_q;
            mem_wen_d   = exe_wen_q;
            mem_br_d    = exe_br_q;
        end
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_pc_d    = wb_pc_q;
        wb_regw_d  = wb_regw_q;
        wb_wen_d   = wb_wen_q;
        if (wb_rst) begin
            wb_valid_d = 1'b0;
            wb_pc_d    = '0;
            wb_regw_d  = '0;
            wb_wen_d   = 1'b0;
        end else if (wb_en) begin
            wb_valid_d = mem_valid_q;
            wb_pc_d    = mem_pc_q;
            wb_regw_d  = mem_regw_q;
            wb_wen_d   = mem_wen_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            exe_valid_q <= 1'b0;
            exe_pc_q    <= '0;
            exe_regw_q  <= '0;
            exe_wen_q   <= 1'b0;
            exe_br_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_pc_q    <= '0;
            mem_regw_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_br_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_pc_q     <= '0;
            wb_regw_q   <= '0;
            wb_wen_q    <= 1'b0;
        end else begin
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            exe_valid_q <= exe_valid_d;
            exe_pc_q    <= exe_pc_d;
            exe_regw_q  <= exe_regw_d;
            exe_wen_q   <= exe_wen_d;
            exe_br_q    <= exe_br_d;
            mem_valid_q <= mem_valid_d;
            mem_pc_q    <= mem_pc_d;
            mem_regw_q  <= mem_regw_d;
            mem_wen_q   <= mem_wen_d;
            mem_br_q    <= mem_br_d;
            wb_valid_q  <= wb_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_regw_q   <= wb_regw_d;
            wb_wen_q    <= wb_wen_d;
        end
    end

    assign if_valid      = if_valid_q;
    assign id_valid      = id_valid_q;
    assign exe_valid     = exe_valid_q;
    assign mem_valid     = mem_valid_q;
    assign wb_valid      = wb_valid_q;
    assign is_branch_exe = exe_br_q;
    assign is_branch_mem = mem_br_q;
    assign regw_addr_exe = exe_regw_q;
    assign regw_addr_mem = mem_regw_q;
    assign regw_addr_wb  = wb_regw_q;
    assign wb_wen_exe    = exe_wen_q;
    assign wb_wen_mem    = mem_wen_q;
    assign wb_wen_wb     = wb_wen_q;
    assign pc_id         = id_pc_q;
    assign pc_exe        = exe_pc_q;
    assign pc_mem        = mem_pc_q;
    assign pc_wb         = wb_pc_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, retire_cnt_q, bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr) begin
            cyc_cnt_q    <= '0;
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
            if (wb_valid_q && wb_en) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            if (exe_rst && id_valid_q) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            if (id_rst && if_valid_q) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign cyc_cnt    = cyc_cnt_q;
    assign retire_cnt = retire_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign cyc_cnt         = '0;
    assign retire_cnt      = '0;
    assign bubble_cnt      = '0;
    assign flush_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_tracker.sv
// Bench for pipe_stage_tracker: stage-array reference model compared every cycle, plus
// directed pipeline scenarios with literal expectations.
module tb_pipe_stage_tracker;

    localparam int unsigned RW = 5;
    localparam int unsigned PW = 32;
    localparam int unsigned CW = 32;
`ifdef PERF_CNT_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    en_v = '0;   // bit 0 = IF ... bit 4 = WB
    logic [4:0]    rst_v = '0;
    logic [PW-1:0] if_pc = '0;
    logic [RW-1:0] id_regw_addr = '0;
    logic          id_wb_wen = 1'b0;
    logic          id_is_branch = 1'b0;
    logic          perf_clr = 1'b0;

    logic          if_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic          is_branch_exe, is_branch_mem;
    logic [RW-1:0] regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic          wb_wen_exe, wb_wen_mem, wb_wen_wb;
    logic [PW-1:0] pc_id, pc_exe, pc_mem, pc_wb;
    logic [CW-1:0] cyc_cnt, retire_cnt, bubble_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pipe_stage_tracker #(.REG_ADDR_W(RW), .PC_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_rst(rst_v[0]), .id_rst(rst_v[1]), .exe_rst(rst_v[2]), .mem_rst(rst_v[3]),
        .wb_rst(rst_v[4]),
        .if_en(en_v[0]), .id_en(en_v[1]), .exe_en(en_v[2]), .mem_en(en_v[3]), .wb_en(en_v[4]),
        .if_pc(if_pc), .id_regw_addr(id_regw_addr), .id_wb_wen(id_wb_wen),
        .id_is_branch(id_is_branch),
        .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
        .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem),
        .regw_addr_wb(regw_addr_wb),
        .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
        .pc_id(pc_id), .pc_exe(pc_exe), .pc_mem(pc_mem), .pc_wb(pc_wb),
        .perf_clr(perf_clr),
        .cyc_cnt(cyc_cnt), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one record per stage, raw (ungated) tags, index 0 = IF.
    bit            m_valid[5], o_valid[5];
    logic [PW-1:0] m_pc[5], o_pc[5];
    logic [RW-1:0] m_regw[5], o_regw[5];
    bit            m_wen[5], o_wen[5];
    bit            m_br[5], o_br[5];
    logic [CW-1:0] m_cyc = '0, m_ret = '0, m_bub = '0, m_fl = '0;

    always @(posedge clk) begin
        o_valid = m_valid;
        o_pc    = m_pc;
        o_regw  = m_regw;
        o_wen   = m_wen;
        o_br    = m_br;
        if (!rst_n || perf_clr) begin
            m_cyc = '0; m_ret = '0; m_bub = '0; m_fl = '0;
        end else begin
            m_cyc = m_cyc + 1;
            if (o_valid[4] && en_v[4]) m_ret = m_ret + 1;
            if (rst_v[2] && o_valid[1]) m_bub = m_bub + 1;
            if (rst_v[1] && o_valid[0]) m_fl = m_fl + 1;
        end
        for (int s = 0; s < 5; s++) begin
            if (!rst_n || rst_v[s]) begin
                m_valid[s] = 1'b0; m_pc[s] = '0; m_regw[s] = '0; m_wen[s] = 1'b0; m_br[s] = 1'b0;
            end else if (en_v[s]) begin
                if (s == 0) begin
                    m_valid[0] = 1'b1; m_pc[0] = if_pc;
                    m_regw[0] = '0; m_wen[0] = 1'b0; m_br[0] = 1'b0;
                end else begin
                    m_valid[s] = o_valid[s-1]; m_pc[s] = o_pc[s-1];
                    m_regw[s] = o_regw[s-1]; m_wen[s] = o_wen[s-1]; m_br[s] = o_br[s-1];
                    if (s == 2) begin
                        m_regw[2] = id_regw_addr; m_wen[2] = id_wb_wen; m_br[2] = id_is_branch;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("if_valid", 32'(if_valid), 32'(m_valid[0]));
            chk("id_valid", 32'(id_valid), 32'(m_valid[1]));
            chk("exe_valid", 32'(exe_valid), 32'(m_valid[2]));
            chk("mem_valid", 32'(mem_valid), 32'(m_valid[3]));
            chk("wb_valid", 32'(wb_valid), 32'(m_valid[4]));
            chk("pc_id", pc_id, m_pc[1]);
            chk("pc_exe", pc_exe, m_pc[2]);
            chk("pc_mem", pc_mem, m_pc[3]);
            chk("pc_wb", pc_wb, m_pc[4]);
            chk("regw_exe", 32'(regw_addr_exe), 32'(m_valid[2] ? m_regw[2] : 5'd0));
            chk("regw_mem", 32'(regw_addr_mem), 32'(m_valid[3] ? m_regw[3] : 5'd0));
            chk("regw_wb", 32'(regw_addr_wb), 32'(m_valid[4] ? m_regw[4] : 5'd0));
            chk("wen_exe", 32'(wb_wen_exe), 32'(m_wen[2] & m_valid[2]));
            chk("wen_mem", 32'(wb_wen_mem), 32'(m_wen[3] & m_valid[3]));
            chk("wen_wb", 32'(wb_wen_wb), 32'(m_wen[4] & m_valid[4]));
            chk("br_exe", 32'(is_branch_exe), 32'(m_br[2] & m_valid[2]));
            chk("br_mem", 32'(is_branch_mem), 32'(m_br[3] & m_valid[3]));
            chk("cyc_cnt", cyc_cnt, PerfOn ? m_cyc : '0);
            chk("retire_cnt", retire_cnt, PerfOn ? m_ret : '0);
            chk("bubble_cnt", bubble_cnt, PerfOn ? m_bub : '0);
            chk("flush_cnt", flush_cnt, PerfOn ? m_fl : '0);
        end
    end

    initial begin
        step();
        chk_en = 1'b1;
        step();
        chk("rst_valids", 32'({wb_valid, mem_valid, exe_valid, id_valid, if_valid}), 32'd0);
        chk("rst_pc_wb", pc_wb, 32'd0);

        // Fill: one more valid stage per edge.
        rst_n = 1'b1;
        en_v  = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            if_pc = 32'(4 * k);
            step();
            chk("fill_valids", 32'({wb_valid, mem_valid, exe_valid, id_valid, if_valid}),
                32'((1 << (k + 1)) - 1));
        end
        chk("fill_pc_wb", pc_wb, 32'h0);
        chk("fill_pc_mem", pc_mem, 32'h4);
        chk("fill_pc_exe", pc_exe, 32'h8);
        chk("fill_pc_id", pc_id, 32'hC);

        // addi $3 in ID (pc 0xC) moves to EXE, then to WB two edges later.
        if_pc = 32'h14; id_regw_addr = 5'd3; id_wb_wen = 1'b1;
        step();
        chk("addi_regw_exe", 32'(regw_addr_exe), 32'd3);
        chk("addi_wen_exe", 32'(wb_wen_exe), 32'd1);
        id_regw_addr = 5'd0; id_wb_wen = 1'b0;
        if_pc = 32'h18; step();
        if_pc = 32'h1C; step();
        chk("addi_regw_wb", 32'(regw_addr_wb), 32'd3);
        chk("addi_pc_wb", pc_wb, 32'hC);
        chk("addi_wen_wb", 32'(wb_wen_wb), 32'd1);

        // Register-hazard stall: IF/ID hold, EXE bubble, MEM/WB advance.
        id_regw_addr = 5'd5; id_wb_wen = 1'b1;
        en_v = 5'b11100; rst_v = 5'b00100;
        step();
        chk("stall_exe_valid", 32'(exe_valid), 32'd0);
        chk("stall_wen_exe", 32'(wb_wen_exe), 32'd0);
        chk("stall_regw_exe", 32'(regw_addr_exe), 32'd0);
        chk("stall_pc_id", pc_id, 32'h18);
        chk("stall_pc_mem", pc_mem, 32'h14);
        step();
        chk("stall_pc_wb", pc_wb, 32'h14);
        chk("stall_pc_id2", pc_id, 32'h18);
        chk("stall_mem_valid", 32'(mem_valid), 32'd0);

        // Branch at pc 0x18 enters EXE, then three ID flushes.
        rst_v = 5'b00000; en_v = 5'b11111;
        id_regw_addr = 5'd0; id_wb_wen = 1'b0; id_is_branch = 1'b1;
        if_pc = 32'h20; step();
        chk("br_exe_set", 32'(is_branch_exe), 32'd1);
        chk("br_pc_exe", pc_exe, 32'h18);
        id_is_branch = 1'b0; rst_v = 5'b00010;
        if_pc = 32'h24; step();
        chk("br_mem_set", 32'(is_branch_mem), 32'd1);
        chk("br_id_flushed", 32'(id_valid), 32'd0);
        chk("br_exe_old_id", pc_exe, 32'h1C);
        if_pc = 32'h28; step();
        chk("br_bubble1", 32'(exe_valid), 32'd0);
        chk("br_pc_wb", pc_wb, 32'h18);
        if_pc = 32'h2C; step();
        chk("br_bubble2", 32'(exe_valid), 32'd0);
        rst_v = 5'b00000;
        if_pc = 32'h30; step();
        chk("br_bubble3", 32'(exe_valid), 32'd0);
        chk("br_resume_pc_id", pc_id, 32'h2C);

        // Debug suspend: all enables low, inputs wiggle, nothing moves.
        en_v = 5'b00000;
        for (int i = 0; i < 10; i++) begin
            if_pc = $urandom;
            id_regw_addr = RW'($urandom);
            id_wb_wen = 1'($urandom);
            id_is_branch = 1'($urandom);
            step();
            chk("freeze_pc_id", pc_id, 32'h2C);
            chk("freeze_valids", 32'({wb_valid, mem_valid, exe_valid, id_valid, if_valid}),
                32'h3);
        end

        // EXE flushed while MEM loads: MEM takes the pre-flush EXE contents.
        en_v = 5'b11111; id_regw_addr = 5'd7; id_wb_wen = 1'b1; id_is_branch = 1'b0;
        if_pc = 32'h34; step();
        if_pc = 32'h38; step();
        rst_v = 5'b00100;
        step();
        chk("flush_mem_pc", pc_mem, 32'h30);
        chk("flush_mem_regw", 32'(regw_addr_mem), 32'd7);
        chk("flush_exe_valid", 32'(exe_valid), 32'd0);
        chk("flush_wb_regw", 32'(regw_addr_wb), 32'd7);
        chk("flush_wb_wen", 32'(wb_wen_wb), 32'd1);

        // Global reset mid-stream wins over every strobe.
        rst_v = 5'b01000; rst_n = 1'b0;
        step();
        chk("mid_rst_valids", 32'({wb_valid, mem_valid, exe_valid, id_valid, if_valid}), 32'd0);
        chk("mid_rst_pc_id", pc_id, 32'd0);
        chk("mid_rst_regw_wb", 32'(regw_addr_wb), 32'd0);
        chk("mid_rst_wen_mem", 32'(wb_wen_mem), 32'd0);
        rst_n = 1'b1; rst_v = 5'b00000; en_v = 5'b00000;
        step();
        chk("post_rst_valids", 32'({wb_valid, mem_valid, exe_valid, id_valid, if_valid}), 32'd0);

        // Counters: clear, then 20 cycles with one stall bubble and three flushes.
        perf_clr = 1'b1; en_v = 5'b11111; if_pc = 32'h100;
        step();
        perf_clr = 1'b0;
        chk("clr_cyc", cyc_cnt, 32'd0);
        chk("clr_retire", retire_cnt, 32'd0);
        chk("clr_bubble", bubble_cnt, 32'd0);
        chk("clr_flush", flush_cnt, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            rst_v = (i == 2) ? 5'b00100 : ((i >= 3 && i <= 5) ? 5'b00010 : 5'b00000);
            if_pc = if_pc + 32'h4;
            step();
        end
        chk("perf_cyc", cyc_cnt, PerfOn ? 32'd20 : 32'd0);
        chk("perf_bubble", bubble_cnt, PerfOn ? 32'd1 : 32'd0);
        chk("perf_flush", flush_cnt, PerfOn ? 32'd3 : 32'd0);
        rst_v = 5'b00000;
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_tracker.md
Name: pipe_stage_tracker

Overview:
- Other end of the pipeline-control interface. Consumes per-stage rst/en strobes from the 5-stage MIPS pipeline controller.
- Produces the stage valid flags (IF/ID/EXE/MEM/WB) and the hazard feedback the controller decodes against: is_branch, regw_addr and wb_wen for EXE and MEM.
- Holds a shadow pipeline of per-instruction control tags (PC, destination register, write enable, branch flag) beside the datapath stage registers.

Parameters:
- REG_ADDR_W, 5, register address width.
- PC_W, 32, PC tag width.
- CNT_W, 32, performance counter width (used only with PERF_CNT_EN).

Ports:
- clk  in  1  main clock
- rst_n  in  1  synchronous reset, active low
- if_rst/id_rst/exe_rst/mem_rst/wb_rst  in  1 each  stage reset (flush) strobes from controller
- if_en/id_en/exe_en/mem_en/wb_en  in  1 each  stage enable strobes from controller
- if_pc  in  PC_W  PC of the instruction being fetched
- id_regw_addr  in  REG_ADDR_W  decoded destination register of the instruction in ID
- id_wb_wen  in  1  decoded write enable of the instruction in ID
- id_is_branch  in  1  decoded jump/branch flag of the instruction in ID (pc_src != next)
- if_valid/id_valid/exe_valid/mem_valid/wb_valid  out  1 each  stage holds a real instruction
- is_branch_exe, is_branch_mem  out  1  branch flag of the EXE/MEM instruction
- regw_addr_exe, regw_addr_mem, regw_addr_wb  out  REG_ADDR_W  destination register per stage
- wb_wen_exe, wb_wen_mem, wb_wen_wb  out  1  write enable per stage
- pc_id, pc_exe, pc_mem, pc_wb  out  PC_W  PC tag per stage
- perf_clr  in  1  clears counters (PERF_CNT_EN only)
- cyc_cnt, retire_cnt, bubble_cnt, flush_cnt  out  CNT_W  counters (PERF_CNT_EN only)

Behaviour:
- Stage register update, every posedge clk, for each stage S, in priority order:
  - rst_n=0: valid and all tags of S are 0.
  - S_rst=1: valid and tags of S are 0. S_rst wins over S_en.
  - S_en=1: S loads the upstream stage's valid and tags.
  - otherwise: S holds.
- Upstream sources per stage:
  - IF: loads valid=1 and pc=if_pc.
  - ID: loads from IF; id_regw_addr, id_wb_wen and id_is_branch are captured when EXE loads from ID.
  - EXE: loads from ID plus the three decoded inputs.
  - MEM: loads from EXE.
  - WB: loads from MEM.
- Required corner cases:
  - Reg-stall pattern (if_en=id_en=0, exe_rst=1): IF and ID hold, EXE becomes a bubble, MEM and WB advance.
  - Branch-stall pattern (id_rst=1, others enabled): ID becomes a bubble, EXE takes the old ID contents.
- Feedback outputs are gated by valid:
  - wb_wen_x = tag & valid_x.
  - is_branch_x = tag & valid_x.
  - regw_addr_x = valid_x ? tag : 0.
  - A bubble therefore never raises a false hazard.
- Outputs are registered; no combinational path from any input to any output. Inputs sampled at a posedge are visible on outputs one cycle later.
- Reset state: all outputs 0. The first cycle after rst_n rises with if_en=1 gives if_valid=1.
- All-stages-disabled (debug suspend, all en=0, no rst): full freeze, outputs constant.
- Simultaneous rst on a stage and en on its downstream stage: the downstream stage captures the pre-reset contents, because old values are read before the clock edge.
- rst_n asserted mid-operation clears every stage in the same edge, whatever the en/rst strobes are.

Optional Feature:
- PERF_CNT_EN. When defined, four CNT_W wrap-around counters are cleared by rst_n=0 or perf_clr=1 (clear takes priority):
  - cyc_cnt: +1 every cycle.
  - retire_cnt: +1 when wb_valid=1 and wb_en=1.
  - bubble_cnt: +1 when exe_rst=1 and id_valid=1 (stall bubble inserted).
  - flush_cnt: +1 when id_rst=1 and if_valid=1.
- When not defined, the counter ports remain and are tied to 0, and no counter flops are synthesised.

Test Plan:
- Reset then 5 cycles with all en=1, if_pc 0x0,0x4,0x8,... -> valids turn on one per cycle. After cycle 5, pc_wb=0x0 and wb_valid=1.
- ID holds addi into $3 (regw=3, wen=1), next edge all en=1 -> regw_addr_exe=3, wb_wen_exe=1. Two edges later regw_addr_wb=3.
- Reg-stall: if_en=id_en=0 and exe_rst=1 for 2 cycles -> exe_valid=0, wb_wen_exe=0, regw_addr_exe=0. pc_id unchanged. The prior EXE instruction reaches MEM then WB.
- Branch: id_is_branch=1 and enter EXE, then id_rst=1 for 3 cycles -> is_branch_exe=1 then is_branch_mem=1. Three consecutive bubbles follow through EXE.
- All en=0 for 10 cycles mid-stream -> every output is constant. rst_n=0 for 1 cycle with en=1 -> all outputs 0 on the next cycle.
- PERF_CNT_EN: 20 cycles with 1 stall bubble and 3 flushes -> cyc_cnt=20, bubble_cnt=1, flush_cnt=3. A perf_clr pulse zeroes all counters. Preload cyc_cnt to 0xFFFFFFFF -> wraps to 0.
